perf_cnt_sampler_arb: RTL and testbench

//  Sits between the CSR file and the perf counter bank's single SRAM-like port (addr/we/wdata/rdata;

---
 rtl/perf_cnt_sampler_arb.sv | 152 +++++++++++++++
 tb/tb_perf_cnt_sampler_arb.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_cnt_sampler_arb.sv
// Shares the perf counter bank port between CSR accesses and a periodic scan engine that streams {addr,value} beats.
// Optional feature: define PERF_SAMPLE_CLEAR_EN to make sampler accesses read-and-clear.
module perf_cnt_sampler_arb #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 64,
    parameter int SCAN_FIRST = 0,
    parameter int SCAN_LAST  = 15,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic [31:0]       period_i,
    input  logic              csr_req_i,
    input  logic              csr_we_i,
    input  logic [ADDR_W-1:0] csr_addr_i,
    input  logic [DATA_W-1:0] csr_wdata_i,
    output logic              csr_gnt_o,
    output logic [DATA_W-1:0] csr_rdata_o,
    output logic [ADDR_W-1:0] cnt_addr_o,
    output logic              cnt_we_o,
    output logic [DATA_W-1:0] cnt_wdata_o,
    input  logic [DATA_W-1:0] cnt_rdata_i,
    output logic              smp_valid_o,
    input  logic              smp_ready_i,
    output logic [ADDR_W-1:0] smp_addr_o,
    output logic [DATA_W-1:0] smp_data_o,
    output logic              smp_last_o,
    output logic              busy_o,
    output logic              overrun_o
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W-1:0]   IDX_FIRST = ADDR_W'(SCAN_FIRST);
    localparam logic [ADDR_W-1:0]   IDX_LAST  = ADDR_W'(SCAN_LAST);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [31:0]         tmr;
    logic                tmr_run;
    logic                trigger;
    logic [ADDR_W-1:0]   idx;
    logic [STARVE_W-1:0] starve;
    logic                smp_win;
    logic                beat_accept;

    // The >= compare lets a shortened period fire on the very next cycle.
    assign tmr_run     = enable_i && (period_i != 32'd0);
    assign trigger     = tmr_run && (tmr >= (period_i - 32'd1));
    assign smp_win     = (state == SCAN) && (!csr_req_i || (starve == STARVE_LIM));
    assign csr_gnt_o   = csr_req_i && !smp_win;
    assign beat_accept = smp_valid_o && smp_ready_i;
    assign busy_o      = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmr <= 32'd0;
        end else if (!tmr_run || trigger) begin
            tmr <= 32'd0;
        end else begin
            tmr <= tmr + 32'd1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (trigger) state_next = SCAN;
            SCAN: if (smp_win) state_next = OUT;
            OUT: begin
                if (beat_accept) begin
                    state_next = (idx == IDX_LAST) ? IDLE : SCAN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx    <= IDX_FIRST;
            starve <= '0;
        end else begin
            if ((state == OUT) && beat_accept) begin
                idx <= (idx == IDX_LAST) ? IDX_FIRST : idx + ADDR_W'(1);
            end
            if ((state != SCAN) || smp_win) begin
                starve <= '0;
            end else if (csr_req_i) begin
                starve <= starve + STARVE_W'(1);
            end
        end
    end

    // One-entry output buffer: loaded on sampler grant, emptied when the sink takes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            smp_valid_o <= 1'b0;
            smp_addr_o  <= '0;
            smp_data_o  <= '0;
            smp_last_o  <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            overrun_o <= trigger && (state != IDLE);
            if (smp_win) begin
                smp_valid_o <= 1'b1;
                smp_addr_o  <= idx;
                smp_data_o  <= cnt_rdata_i;
                smp_last_o  <= (idx == IDX_LAST);
            end else if (beat_accept) begin
                smp_valid_o <= 1'b0;
                smp_last_o  <= 1'b0;
            end
        end
    end

    always_comb begin
        cnt_addr_o  = '0;
        cnt_we_o    = 1'b0;
        cnt_wdata_o = '0;
        csr_rdata_o = '0;
        if (smp_win) begin
            cnt_addr_o = idx;
`ifdef PERF_SAMPLE_CLEAR_EN
            cnt_we_o   = 1'b1;
`else
            cnt_we_o   = 1'b0;
`endif
        end else if (csr_gnt_o) begin
            cnt_addr_o  = csr_addr_i;
            cnt_we_o    = csr_we_i;
            cnt_wdata_o = csr_wdata_i;
            csr_rdata_o = cnt_rdata_i;
        end
    end

endmodule

// File: tb/tb_perf_cnt_sampler_arb.sv
// Randomized bench for perf_cnt_sampler_arb: a behavioural counter bank plus a scan/CSR reference model.
// Expectations follow PERF_SAMPLE_CLEAR_EN when the bench is built with it.
module tb_perf_cnt_sampler_arb;

    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 64;
    localparam int SCAN_FIRST = 0;
    localparam int SCAN_LAST  = 15;
    localparam int STARVE_MAX = 8;
    localparam int NCNT       = 32;
    localparam int NBEAT      = SCAN_LAST - SCAN_FIRST + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [31:0]       period;
    logic              csr_req;
    logic              csr_we;
    logic [ADDR_W-1:0] csr_addr;
    logic [DATA_W-1:0] csr_wdata;
    logic              csr_gnt;
    logic [DATA_W-1:0] csr_rdata;
    logic [ADDR_W-1:0] cnt_addr;
    logic              cnt_we;
    logic [DATA_W-1:0] cnt_wdata;
    logic [DATA_W-1:0] cnt_rdata;
    logic              smp_valid;
    logic              smp_ready;
    logic [ADDR_W-1:0] smp_addr;
    logic [DATA_W-1:0] smp_data;
    logic              smp_last;
    logic              busy;
    logic              overrun;

    logic [2*ADDR_W+3*DATA_W+6-1:0] outs;
    assign outs = {csr_gnt, csr_rdata, cnt_addr, cnt_we, cnt_wdata, smp_valid,
                   smp_addr, smp_data, smp_last, busy, overrun};

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              last;
        int                cyc;
    } beat_t;

    beat_t             got_q[$];
    beat_t             exp_q[$];
    logic [DATA_W-1:0] bank  [NCNT];
    logic [DATA_W-1:0] model [NCNT];
    int                cyc = 0;
    int                ovr_cnt = 0;
    int                n_cmp = 0;
    int                n_err = 0;

    always #5 clk = ~clk;

    perf_cnt_sampler_arb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SCAN_FIRST(SCAN_FIRST),
        .SCAN_LAST(SCAN_LAST), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .period_i(period),
        .csr_req_i(csr_req), .csr_we_i(csr_we), .csr_addr_i(csr_addr),
        .csr_wdata_i(csr_wdata), .csr_gnt_o(csr_gnt), .csr_rdata_o(csr_rdata),
        .cnt_addr_o(cnt_addr), .cnt_we_o(cnt_we), .cnt_wdata_o(cnt_wdata),
        .cnt_rdata_i(cnt_rdata), .smp_valid_o(smp_valid), .smp_ready_i(smp_ready),
        .smp_addr_o(smp_addr), .smp_data_o(smp_data), .smp_last_o(smp_last),
        .busy_o(busy), .overrun_o(overrun)
    );

    // Counter bank: combinational read, write returns old data and stores new at the edge.
    assign cnt_rdata = bank[cnt_addr];
    always @(posedge clk) begin
        if (cnt_we) bank[cnt_addr] <= cnt_wdata;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst_n && smp_valid && smp_ready) got_q.push_back('{smp_addr, smp_data, smp_last, cyc});
        if (overrun) ovr_cnt++;
    end

    // One full scan as seen by the sink: every counter once, in order, last flag only on the final one.
    function automatic void model_scan();
        for (int i = SCAN_FIRST; i <= SCAN_LAST; i++) begin
            exp_q.push_back('{ADDR_W'(i), model[i], (i == SCAN_LAST), 0});
`ifdef PERF_SAMPLE_CLEAR_EN
            model[i] = '0;
`endif
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (busy && t < 200) begin step(); t++; end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_idle: busy=%b required 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        #12;
        @(negedge clk);
        n_cmp++;
        if (outs !== '0) begin n_err++; $display("FAIL reset_outs: got %h required 0", outs); end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (outs !== '0) begin n_err++; $display("FAIL post_reset_outs: got %h required 0", outs); end
        step();
    endtask

    task automatic test_csr();
        int a;
        for (int i = 0; i < NCNT; i++) begin
            csr_req = 1'b1; csr_we = 1'b1; csr_addr = ADDR_W'(i);
            csr_wdata = {$urandom, $urandom};
            @(negedge clk);
            n_cmp++;
            if ({csr_gnt, cnt_addr, cnt_we, cnt_wdata} !== {1'b1, ADDR_W'(i), 1'b1, csr_wdata}) begin
                n_err++;
                $display("FAIL csr_init_port[%0d]: gnt=%b addr=%0d we=%b wdata=%h required 1/%0d/1/%h",
                         i, csr_gnt, cnt_addr, cnt_we, cnt_wdata, i, csr_wdata);
            end
            model[i] = csr_wdata;
            step();
        end
        for (int i = 0; i < 40; i++) begin
            a = $urandom_range(0, NCNT - 1);
            csr_req = 1'b1; csr_we = 1'($urandom_range(0, 1)); csr_addr = ADDR_W'(a);
            csr_wdata = {$urandom, $urandom};
            @(negedge clk);
            n_cmp++;
            if (csr_gnt !== 1'b1 || csr_rdata !== model[a]) begin
                n_err++;
                $display("FAIL csr_access[%0d]: gnt=%b rdata=%h required 1/%h", a, csr_gnt, csr_rdata, model[a]);
            end
            if (csr_we) model[a] = csr_wdata;
            step();
        end
        csr_req = 1'b0; csr_we = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (outs !== '0) begin n_err++; $display("FAIL csr_idle_port: got %h required 0", outs); end
        step();
    endtask

    task automatic test_scan_period();
        int p, t, o0, bad;
        got_q.delete(); exp_q.delete();
        model_scan(); model_scan();
        p = $urandom_range(40, 60);
        o0 = ovr_cnt;
        period = 32'(p); smp_ready = 1'b1; enable = 1'b1;
        t = 0;
        while (got_q.size() < 2 * NBEAT && t < 500) begin step(); t++; end
        enable = 1'b0;
        wait_idle("scan_period");
        n_cmp++;
        if (got_q.size() != 2 * NBEAT) begin
            n_err++; $display("FAIL scan_count: got %0d beats required %0d", got_q.size(), 2 * NBEAT);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= got_q.size()) begin
                n_err++; $display("FAIL scan_beat[%0d]: missing, required addr %0d", i, exp_q[i].addr);
            end else if ({got_q[i].addr, got_q[i].data, got_q[i].last} !== {exp_q[i].addr, exp_q[i].data, exp_q[i].last}) begin
                n_err++;
                $display("FAIL scan_beat[%0d]: got %0d/%h/%b required %0d/%h/%b", i, got_q[i].addr,
                         got_q[i].data, got_q[i].last, exp_q[i].addr, exp_q[i].data, exp_q[i].last);
            end
        end
        n_cmp++;
        if (got_q.size() < 2 * NBEAT || got_q[NBEAT].cyc - got_q[0].cyc != p) begin
            n_err++; $display("FAIL scan_interval: scan starts not %0d cycles apart", p);
        end
        bad = 0;
        for (int i = 0; i + 1 < got_q.size(); i++) begin
            if ((i % NBEAT) != NBEAT - 1 && got_q[i + 1].cyc - got_q[i].cyc != 2) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL scan_beat_spacing: got %0d bad gaps required 0", bad); end
        n_cmp++;
        if (ovr_cnt != o0) begin n_err++; $display("FAIL scan_no_overrun: got %0d pulses required 0", ovr_cnt - o0); end
    endtask

    task automatic test_starve();
        int a, t, forced, bad;
        got_q.delete(); exp_q.delete();
        model_scan();
        a = $urandom_range(SCAN_LAST + 1, NCNT - 1);
        period = 32'd200; smp_ready = 1'b1; enable = 1'b1;
        csr_req = 1'b1; csr_we = 1'b0; csr_addr = ADDR_W'(a);
        forced = 0; t = 0;
        while (got_q.size() < NBEAT && t < 700) begin
            @(negedge clk);
            if (csr_gnt) begin
                n_cmp++;
                if (csr_rdata !== model[a]) begin
                    n_err++; $display("FAIL starve_csr_rdata[%0d]: got %h required %h", a, csr_rdata, model[a]);
                end
            end else begin
                forced++;
            end
            step(); t++;
        end
        csr_req = 1'b0; enable = 1'b0;
        wait_idle("starve");
        n_cmp++;
        if (forced != NBEAT) begin n_err++; $display("FAIL starve_forced: got %0d required %0d", forced, NBEAT); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= got_q.size()) begin
                n_err++; $display("FAIL starve_beat[%0d]: missing, required addr %0d", i, exp_q[i].addr);
            end else if ({got_q[i].addr, got_q[i].data, got_q[i].last} !== {exp_q[i].addr, exp_q[i].data, exp_q[i].last}) begin
                n_err++;
                $display("FAIL starve_beat[%0d]: got %0d/%h/%b required %0d/%h/%b", i, got_q[i].addr,
                         got_q[i].data, got_q[i].last, exp_q[i].addr, exp_q[i].data, exp_q[i].last);
            end
        end
        bad = 0;
        for (int i = 0; i + 1 < got_q.size(); i++) begin
            if (got_q[i + 1].cyc - got_q[i].cyc != STARVE_MAX + 2) bad++;
        end
        n_cmp++;
        if (bad != 0 || got_q.size() < NBEAT) begin
            n_err++; $display("FAIL starve_spacing: got %0d bad gaps required 0", bad);
        end
    endtask

    task automatic test_stall();
        int t;
        bit found;
        got_q.delete(); exp_q.delete();
        model_scan();
        period = 32'd100; smp_ready = 1'b1; enable = 1'b1;
        found = 0; t = 0;
        while (!found && t < 300) begin
            @(negedge clk);
            t++;
            if (cnt_addr === ADDR_W'(SCAN_FIRST + 3)) found = 1;
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL stall_reach_idx3: got no read of idx 3 required one"); end
        step();
        smp_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({smp_valid, smp_addr, smp_data, smp_last} !== {1'b1, exp_q[3].addr, exp_q[3].data, 1'b0}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got %b/%0d/%h/%b required 1/%0d/%h/0", i, smp_valid,
                         smp_addr, smp_data, smp_last, exp_q[3].addr, exp_q[3].data);
            end
            n_cmp++;
            if ({cnt_addr, cnt_we} !== '0) begin
                n_err++; $display("FAIL stall_port_idle[%0d]: addr=%0d we=%b required 0/0", i, cnt_addr, cnt_we);
            end
            step();
        end
        smp_ready = 1'b1;
        t = 0;
        while (got_q.size() < NBEAT && t < 200) begin step(); t++; end
        enable = 1'b0;
        wait_idle("stall");
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= got_q.size()) begin
                n_err++; $display("FAIL stall_beat[%0d]: missing, required addr %0d", i, exp_q[i].addr);
            end else if ({got_q[i].addr, got_q[i].data, got_q[i].last} !== {exp_q[i].addr, exp_q[i].data, exp_q[i].last}) begin
                n_err++;
                $display("FAIL stall_beat[%0d]: got %0d/%h/%b required %0d/%h/%b", i, got_q[i].addr,
                         got_q[i].data, got_q[i].last, exp_q[i].addr, exp_q[i].data, exp_q[i].last);
            end
        end
    endtask

    task automatic test_overrun();
        int pulses, bad_pulse, bad_busy, o0;
        logic prev;
        got_q.delete(); exp_q.delete();
        model_scan();
        period = 32'd4; smp_ready = 1'b0; enable = 1'b1;
        repeat (12) step();
        pulses = 0; bad_pulse = 0; bad_busy = 0; prev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (overrun) begin
                pulses++;
                if (prev) bad_pulse++;
            end
            prev = overrun;
            if (!busy || !smp_valid || smp_addr !== ADDR_W'(SCAN_FIRST)) bad_busy++;
            step();
        end
        n_cmp++;
        if (pulses != 10) begin n_err++; $display("FAIL overrun_pulses: got %0d required 10", pulses); end
        n_cmp++;
        if (bad_pulse != 0) begin n_err++; $display("FAIL overrun_width: got %0d long pulses required 0", bad_pulse); end
        n_cmp++;
        if (bad_busy != 0) begin n_err++; $display("FAIL overrun_scan_held: got %0d bad cycles required 0", bad_busy); end
        enable = 1'b0; smp_ready = 1'b1;
        wait_idle("overrun");
        n_cmp++;
        if (got_q.size() != NBEAT) begin n_err++; $display("FAIL overrun_beats: got %0d required %0d", got_q.size(), NBEAT); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if ({got_q[i].addr, got_q[i].data, got_q[i].last} !== {exp_q[i].addr, exp_q[i].data, exp_q[i].last}) begin
                n_err++;
                $display("FAIL overrun_beat[%0d]: got %0d/%h/%b required %0d/%h/%b", i, got_q[i].addr,
                         got_q[i].data, got_q[i].last, exp_q[i].addr, exp_q[i].data, exp_q[i].last);
            end
        end
        o0 = ovr_cnt; bad_busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) bad_busy++;
            step();
        end
        n_cmp++;
        if (bad_busy != 0 || ovr_cnt != o0) begin
            n_err++; $display("FAIL enable_off_quiet: got %0d busy cycles, %0d pulses required 0/0", bad_busy, ovr_cnt - o0);
        end
    endtask

    task automatic test_reset_midscan();
        int t;
        bit found;
        got_q.delete(); exp_q.delete();
        period = 32'd100; smp_ready = 1'b1; enable = 1'b1;
        found = 0; t = 0;
        while (!found && t < 300) begin
            @(negedge clk);
            t++;
            if (cnt_addr === ADDR_W'(SCAN_FIRST + 7)) found = 1;
        end
        step();
        smp_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({found, smp_valid, smp_addr} !== {1'b1, 1'b1, ADDR_W'(SCAN_FIRST + 7)}) begin
            n_err++; $display("FAIL rst_mid_pending: got valid=%b addr=%0d required 1/7", smp_valid, smp_addr);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (outs !== '0) begin n_err++; $display("FAIL rst_mid_outs: got %h required 0", outs); end
        n_cmp++;
        if (got_q.size() != 7) begin n_err++; $display("FAIL rst_mid_count: got %0d required 7", got_q.size()); end
        for (int i = 0; i < 7 && i < got_q.size(); i++) begin
            n_cmp++;
            if ({got_q[i].addr, got_q[i].data, got_q[i].last} !== {ADDR_W'(SCAN_FIRST + i), model[SCAN_FIRST + i], 1'b0}) begin
                n_err++;
                $display("FAIL rst_mid_beat[%0d]: got %0d/%h/%b required %0d/%h/0", i, got_q[i].addr,
                         got_q[i].data, got_q[i].last, SCAN_FIRST + i, model[SCAN_FIRST + i]);
            end
        end
`ifdef PERF_SAMPLE_CLEAR_EN
        for (int i = SCAN_FIRST; i <= SCAN_FIRST + 7; i++) model[i] = '0;
`endif
        step(); step();
        rst_n = 1'b1; smp_ready = 1'b1;
        got_q.delete();
        model_scan();
        t = 0;
        while (got_q.size() < NBEAT && t < 300) begin step(); t++; end
        enable = 1'b0;
        wait_idle("rst_mid");
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= got_q.size()) begin
                n_err++; $display("FAIL rst_rescan_beat[%0d]: missing, required addr %0d", i, exp_q[i].addr);
            end else if ({got_q[i].addr, got_q[i].data, got_q[i].last} !== {exp_q[i].addr, exp_q[i].data, exp_q[i].last}) begin
                n_err++;
                $display("FAIL rst_rescan_beat[%0d]: got %0d/%h/%b required %0d/%h/%b", i, got_q[i].addr,
                         got_q[i].data, got_q[i].last, exp_q[i].addr, exp_q[i].data, exp_q[i].last);
            end
        end
    endtask

    task automatic test_readback();
        for (int i = 0; i < NCNT; i++) begin
            csr_req = 1'b1; csr_we = 1'b0; csr_addr = ADDR_W'(i);
            @(negedge clk);
            n_cmp++;
            if (csr_gnt !== 1'b1 || csr_rdata !== model[i]) begin
                n_err++; $display("FAIL readback[%0d]: gnt=%b rdata=%h required 1/%h", i, csr_gnt, csr_rdata, model[i]);
            end
            step();
        end
        csr_req = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; period = 32'd0; csr_req = 1'b0; csr_we = 1'b0;
        csr_addr = '0; csr_wdata = '0; smp_ready = 1'b0;
        test_reset();
        test_csr();
        test_scan_period();
        test_starve();
        test_stall();
        test_overrun();
        test_reset_midscan();
        test_readback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
